// File: rtl/stream_mux_n_if.sv
// ----------------------------------------------------------------------------
// stream_mux_n_if
//
// Purpose: groups the handshake and data signals of the N-channel streaming
// multiplexer into a single bundle. It covers the producer side (per-channel
// data/valid/ready), the select controls, and the consumer side
// (data/channel/valid/ready).
//
// Parameters:
//   N_CH  - number of input channels
//   W     - data width per channel
//   SEL_W - width of the channel index
//
// Signals:
//   in_data   [N_CH*W]  channel k at bits [k*W+W-1 : k*W]
//   in_valid  [N_CH]    per-channel valid
//   in_ready  [N_CH]    per-channel accept (at most one bit high)
//   sel       [SEL_W]   channel select for fixed mode
//   mode      [1]       0 = fixed select, 1 = round-robin
//   out_data  [W]       registered selected data
//   out_ch    [SEL_W]   index of the channel that produced out_data
//   out_valid [1]       output register holds data
//   out_ready [1]       consumer accepts out_data
//
// Modports:
//   master - environment side (producers + consumer)
//   slave  - multiplexer side
// ----------------------------------------------------------------------------
interface stream_mux_n_if #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
);
    logic [N_CH*W-1:0] in_data;
    logic [N_CH-1:0]   in_valid;
    logic [N_CH-1:0]   in_ready;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, sel, mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_n.sv
// ----------------------------------------------------------------------------
// stream_mux_n
//
// Purpose: N-channel, W-bit streaming multiplexer with a one-entry registered
// output stage and valid/ready handshakes on every channel. A single channel
// is granted per cycle. In fixed mode the grant goes to the channel on sel.
// In round-robin mode it goes to the first valid channel after the last
// granted one.
//
// Optional feature macro: STREAM_MUX_RR_EN
//   defined   - round-robin arbiter and last-grant pointer are built; mode
//               selects fixed or round-robin grant.
//   undefined - arbiter and pointer are removed; mode is ignored and the
//               block always uses the fixed select.
//
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous, active-low reset
//   bus     - stream_mux_n_if.slave bundle (see interface file for signals)
// ----------------------------------------------------------------------------
module stream_mux_n #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stream_mux_n_if.slave        bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    logic [W-1:0]     data_q;
    logic [SEL_W-1:0] ch_q;

    logic             fixed_valid;
    logic             grant_valid;
    logic [SEL_W-1:0] grant_idx;
    logic [W-1:0]     grant_data;
    logic             load_en;

    // Fixed-mode grant: the channel on sel. A sel value of N_CH or above
    // matches no channel, so fixed_valid stays low and nothing is granted.
    always_comb begin
        fixed_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                fixed_valid = bus.in_valid[k];
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0] last;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;

    // Round-robin search. Try offsets 1..N_CH from the last grant, wrapping
    // at N_CH. The first valid channel wins, so the previous winner is tried
    // last.
    always_comb begin
        int cand;
        rr_valid = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int off = 1; off <= N_CH; off++) begin
            cand = int'(last) + off;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (!rr_valid && cand == k && bus.in_valid[k]) begin
                    rr_valid = 1'b1;
                    rr_idx   = SEL_W'(k);
                end
            end
        end
    end

    // Pick the arbiter output that matches mode.
    always_comb begin
        if (bus.mode) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = fixed_valid;
            grant_idx   = bus.sel;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = bus.mode;

    always_comb begin
        grant_valid = fixed_valid;
        grant_idx   = bus.sel;
    end
`endif

    // Select the granted channel's data with constant slices.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = bus.in_data[k*W +: W];
            end
        end
    end

    // Load when the granted channel is valid and the output register is
    // empty or draining this cycle. Gating with reset_n keeps in_ready low
    // while reset is held, even though in_valid may already be high.
    assign load_en = reset_n && grant_valid && (state == EMPTY || bus.out_ready);

    // One-hot accept for the granted channel only.
    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < N_CH; k++) begin
            bus.in_ready[k] = load_en && (grant_idx == SEL_W'(k));
        end
    end

    // Output stage FSM. Loading always leaves it FULL, which covers the
    // back-to-back case. A transfer without a new load empties it. With no
    // transfer and no load, the held entry stays as it is.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            data_q <= '0;
            ch_q   <= '0;
        end else if (load_en) begin
            state  <= FULL;
            data_q <= grant_data;
            ch_q   <= grant_idx;
        end else if (state == FULL && bus.out_ready) begin
            state  <= EMPTY;
        end
    end

`ifdef STREAM_MUX_RR_EN
    // Last-grant pointer. Its reset value is N_CH-1 so that the first
    // round-robin search starts at channel 0. It updates on every load in
    // either mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= SEL_W'(N_CH - 1);
        end else if (load_en) begin
            last <= grant_idx;
        end
    end
`endif

    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// ----------------------------------------------------------------------------
// tb_stream_mux_n
//
// Purpose: directed self-checking bench for stream_mux_n. It drives a 4-channel
// instance through reset, fixed select, back-pressure, back-to-back streaming,
// the no-valid case and an asynchronous mid-stream reset. It also runs the
// round-robin or mode-ignored sequence, depending on STREAM_MUX_RR_EN. A
// second 3-channel instance covers the out-of-range select.
// ----------------------------------------------------------------------------
module tb_stream_mux_n;

    logic clk;
    logic reset_n;

    int compared   = 0;
    int mismatched = 0;

    stream_mux_n_if #(.N_CH(4), .W(8), .SEL_W(2)) bus ();
    stream_mux_n_if #(.N_CH(3), .W(8), .SEL_W(2)) bus3 ();

    stream_mux_n #(.N_CH(4), .W(8), .SEL_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    stream_mux_n #(.N_CH(3), .W(8), .SEL_W(2)) dut3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its hand-computed expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive the 4-channel instance's control inputs.
    task automatic applyStimulus(input logic [3:0] valid, input logic [1:0] s,
                                 input logic m, input logic ordy);
        bus.in_valid  = valid;
        bus.sel       = s;
        bus.mode      = m;
        bus.out_ready = ordy;
    endtask

    task automatic setChannel(input int k, input logic [7:0] v);
        case (k)
            0: bus.in_data[7:0]   = v;
            1: bus.in_data[15:8]  = v;
            2: bus.in_data[23:16] = v;
            default: bus.in_data[31:24] = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int rr_all [6]  = '{0, 1, 2, 3, 0, 1};
    int rr_skip [4] = '{3, 1, 3, 1};

    initial begin
        reset_n        = 1'b0;
        bus.in_data    = '0;
        applyStimulus(4'b0000, 2'd0, 1'b0, 1'b0);
        bus3.in_data   = '0;
        bus3.in_valid  = '0;
        bus3.sel       = '0;
        bus3.mode      = 1'b0;
        bus3.out_ready = 1'b1;

        // Reset state
        #12;
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_out_data",  32'(bus.out_data),  32'h00);
        checkOutput("reset_out_ch",    32'(bus.out_ch),    32'd0);
        checkOutput("reset_in_ready",  32'(bus.in_ready),  32'h0);
        #1 reset_n = 1'b1;

        // Fixed select of channel 2
        setChannel(2, 8'hA5);
        applyStimulus(4'b0100, 2'd2, 1'b0, 1'b1);
        #1 checkOutput("fixed_in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        checkOutput("fixed_out_data",  32'(bus.out_data),  32'hA5);
        checkOutput("fixed_out_ch",    32'(bus.out_ch),    32'd2);
        checkOutput("fixed_out_valid", 32'(bus.out_valid), 32'd1);
        applyStimulus(4'b0000, 2'd2, 1'b0, 1'b1);
        #1 checkOutput("fixed_in_ready_off", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("fixed_drained", 32'(bus.out_valid), 32'd0);

        // Back-pressure: load 0x11 from ch1, then stall for five cycles
        setChannel(1, 8'h11);
        applyStimulus(4'b0010, 2'd1, 1'b0, 1'b0);
        #1 checkOutput("bp_load_in_ready", 32'(bus.in_ready), 32'b0010);
        tick();
        checkOutput("bp_loaded_data", 32'(bus.out_data), 32'h11);
        checkOutput("bp_loaded_ch",   32'(bus.out_ch),   32'd1);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) setChannel(k, 8'(8'hE0 + i + k));
            applyStimulus(4'b1111, 2'(i), 1'b0, 1'b0);
            #1 checkOutput("bp_in_ready_zero", 32'(bus.in_ready), 32'h0);
            tick();
            checkOutput("bp_hold_data",  32'(bus.out_data),  32'h11);
            checkOutput("bp_hold_ch",    32'(bus.out_ch),    32'd1);
            checkOutput("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        end
        applyStimulus(4'b0000, 2'd1, 1'b0, 1'b1);
        #1 checkOutput("bp_release_valid", 32'(bus.out_valid), 32'd1);
        tick();
        checkOutput("bp_single_transfer", 32'(bus.out_valid), 32'd0);

        // Back-to-back streaming from ch0
        applyStimulus(4'b0001, 2'd0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            setChannel(0, 8'(8'h30 + j));
            #1 checkOutput("b2b_in_ready", 32'(bus.in_ready), 32'b0001);
            tick();
            checkOutput("b2b_out_data",  32'(bus.out_data),  32'(8'h30 + j));
            checkOutput("b2b_out_valid", 32'(bus.out_valid), 32'd1);
        end
        applyStimulus(4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("b2b_drained", 32'(bus.out_valid), 32'd0);

        // Granted channel not valid: no load
        applyStimulus(4'b0001, 2'd3, 1'b0, 1'b1);
        #1 checkOutput("noload_in_ready", 32'(bus.in_ready), 32'h0);
        tick();
        checkOutput("noload_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("noload_out_valid2", 32'(bus.out_valid), 32'd0);

        // N_CH=3: sel=3 is out of range, sel=2 is the top channel
        bus3.in_data  = 24'h7E_5A_3C;
        bus3.in_valid = 3'b111;
        bus3.sel      = 2'd3;
        #1 checkOutput("n3_sel3_in_ready", 32'(bus3.in_ready), 32'h0);
        tick();
        checkOutput("n3_sel3_out_valid", 32'(bus3.out_valid), 32'd0);
        bus3.sel = 2'd2;
        #1 checkOutput("n3_sel2_in_ready", 32'(bus3.in_ready), 32'b100);
        tick();
        checkOutput("n3_sel2_out_ch",   32'(bus3.out_ch),   32'd2);
        checkOutput("n3_sel2_out_data", 32'(bus3.out_data), 32'h7E);
        bus3.in_valid = 3'b000;

        // Asynchronous reset while FULL and stalled
        setChannel(2, 8'hC3);
        applyStimulus(4'b0100, 2'd2, 1'b0, 1'b0);
        tick();
        checkOutput("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("rst_pre_data",  32'(bus.out_data),  32'hC3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_async_valid",    32'(bus.out_valid), 32'd0);
        checkOutput("rst_async_data",     32'(bus.out_data),  32'h00);
        checkOutput("rst_async_ch",       32'(bus.out_ch),    32'd0);
        checkOutput("rst_async_in_ready", 32'(bus.in_ready),  32'h0);
        #1 reset_n = 1'b1;

        for (int k = 0; k < 4; k++) setChannel(k, 8'(8'h40 + k));
`ifdef STREAM_MUX_RR_EN
        // Round-robin, all valid: 0,1,2,3,0,1 starting from reset
        applyStimulus(4'b1111, 2'd3, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            #1 checkOutput("rr_all_in_ready", 32'(bus.in_ready), 32'(4'b0001 << rr_all[i]));
            tick();
            checkOutput("rr_all_out_ch",   32'(bus.out_ch),   32'(rr_all[i]));
            checkOutput("rr_all_out_data", 32'(bus.out_data), 32'(8'h40 + rr_all[i]));
        end
        // Skip invalid channels: last=1, so 3,1,3,1
        applyStimulus(4'b1010, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1 checkOutput("rr_skip_in_ready", 32'(bus.in_ready), 32'(4'b0001 << rr_skip[i]));
            tick();
            checkOutput("rr_skip_out_ch", 32'(bus.out_ch), 32'(rr_skip[i]));
        end
        // Only ch1 valid: 1,1,1
        applyStimulus(4'b0010, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("rr_single_in_ready", 32'(bus.in_ready), 32'b0010);
            tick();
            checkOutput("rr_single_out_ch", 32'(bus.out_ch), 32'd1);
        end
`else
        // Without the arbiter, mode=1 still grants the channel on sel
        applyStimulus(4'b1111, 2'd2, 1'b1, 1'b1);
        #1 checkOutput("mode_ignored_in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        checkOutput("mode_ignored_out_ch",   32'(bus.out_ch),   32'd2);
        checkOutput("mode_ignored_out_data", 32'(bus.out_data), 32'h42);
        applyStimulus(4'b1111, 2'd1, 1'b1, 1'b1);
        tick();
        checkOutput("mode_ignored_out_ch2", 32'(bus.out_ch), 32'd1);
`endif

        applyStimulus(4'b0000, 2'd0, 1'b0, 1'b1);
        tick();
        checkOutput("final_drained", 32'(bus.out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
